fifo_fwft_reader: RTL and testbench

FIFO_FWFT_READER -- requirements
Module: fifo_fwft_reader

---
 rtl/fifo_fwft_reader_pkg.sv | 31 +++
 rtl/fifo_fwft_reader_if.sv | 31 +++
 rtl/fifo_fwft_reader_rate_lfsr.sv | 35 +++
 rtl/fifo_fwft_reader.sv | 136 +++++++++++++
 tb/tb_fifo_fwft_reader.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_fwft_reader_pkg.sv
// ----------------------------------------------------------------------------
// fifo_fwft_reader_pkg
// Shared definitions for the FWFT block reader:
//   - state_t       : reader FSM states (IDLE / READ / DONE)
//   - THR_W         : width of the throttle level and of the compared LFSR slice
//   - LFSR_SEED     : reset value of the throttle LFSR
//   - LFSR_TAPS     : Fibonacci tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   - lfsr_next()   : one-step advance of the throttle LFSR
// ----------------------------------------------------------------------------
package fifo_fwft_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          THR_W     = 8;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Taps 16,14,13,11 expressed as zero-based bit positions 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shift left, feeding back the XOR of the tapped bits into bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic fb;
        fb = ^(cur & LFSR_TAPS);
        return {cur[14:0], fb};
    endfunction

endpackage

// File: rtl/fifo_fwft_reader_if.sv
// ----------------------------------------------------------------------------
// fifo_fwft_reader_if
// Pop-side connection of a first-word-fall-through FIFO.
//   din   : head word, valid whenever empty is low
//   empty : FIFO empty flag
//   rden  : pop strobe; the word on din is consumed in the cycle rden is high
// Modports:
//   master : the reader (drives rden, observes din/empty)
//   slave  : the FIFO   (drives din/empty, observes rden)
// ----------------------------------------------------------------------------
interface fifo_fwft_reader_if #(
    parameter int WIDTH = 32
) ();

    logic [WIDTH-1:0] din;
    logic             empty;
    logic             rden;

    modport master (
        input  din,
        input  empty,
        output rden
    );

    modport slave (
        output din,
        output empty,
        input  rden
    );

endinterface

// File: rtl/fifo_fwft_reader_rate_lfsr.sv
// ----------------------------------------------------------------------------
// fwft_rate_lfsr
// Pseudo-random read throttle. A 16-bit Fibonacci LFSR advances every clock;
// the low THR_W bits are compared against the requested rate, so the fraction
// of enabled cycles is roughly (rate+1)/256. rate = 8'hFF enables every cycle.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-low reset (reloads the seed)
//   rate   : throttle level
//   thr_en : read enable for the current cycle
// ----------------------------------------------------------------------------
module fwft_rate_lfsr
    import fifo_fwft_reader_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [THR_W-1:0] rate,
    output logic             thr_en
);

    logic [15:0] r_lfsr;

    // LFSR state: reseed on reset, otherwise step once per clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // An all-ones rate makes the compare always true.
    assign thr_en = (r_lfsr[THR_W-1:0] <= rate);

endmodule

// File: rtl/fifo_fwft_reader.sv
// ----------------------------------------------------------------------------
// fifo_fwft_reader
// Reads one block of words from an FWFT FIFO into a wide output register.
// A start pulse in IDLE latches min(length, MAX_BLOCK_SIZE), clears the block
// and the word counter, then pops words in FIFO order into consecutive slots
// while the FIFO is not empty and the throttle allows. done pulses for one
// cycle after the last pop; data_o/count then hold until the next start.
// Ports:
//   clk, rst : clock and asynchronous active-low reset
//   fifo     : FWFT pop interface (master side: din, empty in; rden out)
//   start    : one-cycle block request (ignored unless IDLE)
//   length   : words in the requested block
//   rate     : throttle level, 8'hFF = full speed
//   data_o   : assembled block, word k at [k*WIDTH +: WIDTH]
//   count    : words captured so far
//   busy     : block in progress (READ or DONE)
//   done     : one-cycle completion pulse
// ----------------------------------------------------------------------------
module fifo_fwft_reader
    import fifo_fwft_reader_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int MAX_BLOCK_SIZE = 32,
    localparam int CW            = $clog2(MAX_BLOCK_SIZE + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    fifo_fwft_reader_if.master              fifo,
    input  logic                            start,
    input  logic [CW-1:0]                   length,
    input  logic [THR_W-1:0]                rate,
    output logic [MAX_BLOCK_SIZE*WIDTH-1:0] data_o,
    output logic [CW-1:0]                   count,
    output logic                            busy,
    output logic                            done
);

    localparam logic [CW-1:0] MAX_LEN = CW'(MAX_BLOCK_SIZE);

    state_t                          r_state;
    logic [MAX_BLOCK_SIZE*WIDTH-1:0] r_data;
    logic [CW-1:0]                   r_count;
    logic [CW-1:0]                   r_len;
    logic                            r_busy;
    logic                            r_done;

    logic                            w_thr_en;
    logic                            w_rden;
    logic [CW-1:0]                   w_len_eff;
    logic                            w_last;

    fwft_rate_lfsr u_rate_lfsr (
        .clk    (clk),
        .rst    (rst),
        .rate   (rate),
        .thr_en (w_thr_en)
    );

    // Requests longer than the block buffer are clipped to its size.
    assign w_len_eff = (length > MAX_LEN) ? MAX_LEN : length;

    // The pop is combinational so the head word is consumed in the same cycle.
    assign w_rden = (r_state == ST_READ) & ~fifo.empty & w_thr_en;

    // r_len is at least 1 whenever READ is entered, so this never wraps there.
    assign w_last = (r_count == (r_len - CW'(1)));

    // Reader FSM with its datapath and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_data  <= '0;
                        r_count <= '0;
                        r_len   <= w_len_eff;
                        r_busy  <= 1'b1;
                        if (w_len_eff == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_READ;
                            r_done  <= 1'b0;
                        end
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b0;
                    end
                end

                ST_READ: begin
                    if (w_rden) begin
                        // Slot selection by comparison keeps the write index
                        // inside the buffer for every counter value.
                        for (int k = 0; k < MAX_BLOCK_SIZE; k++) begin
                            if (r_count == CW'(k)) begin
                                r_data[k*WIDTH +: WIDTH] <= fifo.din;
                            end
                        end
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.rden = w_rden;
    assign data_o    = r_data;
    assign count     = r_count;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_fifo_fwft_reader.sv
module tb_fifo_fwft_reader;

    localparam int W   = 32;
    localparam int MAX = 32;
    localparam int CW  = $clog2(MAX + 1);

    logic            clk;
    logic            rst;
    logic            start;
    logic [CW-1:0]   length;
    logic [7:0]      rate;
    logic [MAX*W-1:0] data_o;
    logic [CW-1:0]   count;
    logic            busy;
    logic            done;

    fifo_fwft_reader_if #(.WIDTH(W)) fif ();

    fifo_fwft_reader #(.WIDTH(W), .MAX_BLOCK_SIZE(MAX)) dut (
        .clk    (clk),
        .rst    (rst),
        .fifo   (fif),
        .start  (start),
        .length (length),
        .rate   (rate),
        .data_o (data_o),
        .count  (count),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    int cyc_n = 0;
    bit stall_mode = 1'b0;
    bit stall_now  = 1'b0;
    int n_pops, n_read, n_rden_bad, n_done, first_pop, last_pop, done_cyc, start_cyc;
    bit pop_now;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return data_o[k*W +: W];
    endfunction

    task automatic clear_stats();
        n_pops = 0; n_read = 0; n_rden_bad = 0; n_done = 0;
        first_pop = -1; last_pop = -1; done_cyc = -1;
    endtask

    // One clock cycle: present FIFO head at negedge, sample, let the edge pass.
    task automatic cyc();
        if (q.size() > 0 && !stall_now) begin
            fif.din = q[0]; fif.empty = 1'b0;
        end else begin
            fif.din = '0;   fif.empty = 1'b1;
        end
        #1;
        if (busy && !done) n_read++;
        if (done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc_n;
        end
        pop_now = fif.rden;
        if (fif.rden) begin
            n_pops++;
            if (first_pop < 0) first_pop = cyc_n;
            last_pop = cyc_n;
            if (fif.empty) n_rden_bad++;
        end
        @(posedge clk);
        if (pop_now && q.size() > 0) q.delete(0);
        @(negedge clk);
        cyc_n++;
        stall_now = stall_mode && cyc_n[0];
    endtask

    // Issue a block request and run until done (or the budget expires).
    task automatic run_block(input int len, input int budget, input int restart_at, input int restart_len);
        int g;
        clear_stats();
        start = 1'b1; length = CW'(len);
        start_cyc = cyc_n;
        cyc();
        start = 1'b0;
        g = 0;
        while (n_done == 0 && g < budget) begin
            if (g == restart_at) begin
                start = 1'b1; length = CW'(restart_len);
            end
            cyc();
            start = 1'b0;
            g++;
        end
        check("block_completed_within_budget", 64'(n_done), 64'd1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; length = '0; rate = 8'hFF;
        fif.din = '0; fif.empty = 1'b1;
        q.delete();
        repeat (2) @(negedge clk);
        fif.empty = 1'b0; fif.din = 32'hDEAD_BEEF;
        #1;
        check("reset_busy",  64'(busy),   64'd0);
        check("reset_done",  64'(done),   64'd0);
        check("reset_rden",  64'(fif.rden), 64'd0);
        check("reset_count", 64'(count),  64'd0);
        check("reset_data_nonzero", 64'(|data_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) cyc();

        // Full-speed 8-word block
        for (int i = 1; i <= 8; i++) q.push_back(32'(i));
        run_block(8, 50, -1, 0);
        check("full_pops",      64'(n_pops),    64'd8);
        check("full_first_pop", 64'(first_pop), 64'(start_cyc + 1));
        check("full_last_pop",  64'(last_pop),  64'(start_cyc + 8));
        check("full_done_cyc",  64'(done_cyc),  64'(start_cyc + 9));
        check("full_count",     64'(count),     64'd8);
        for (int k = 0; k < 8; k++) check("full_word", 64'(word(k)), 64'(k + 1));
        check("full_upper_zero", 64'(|data_o[MAX*W-1:8*W]), 64'd0);
        cyc();
        check("full_idle_busy", 64'(busy), 64'd0);
        check("full_hold_count", 64'(count), 64'd8);
        check("full_hold_word7", 64'(word(7)), 64'd8);

        // Stalled 4-word block, empty toggling
        q.push_back(32'hA0); q.push_back(32'hA1); q.push_back(32'hA2); q.push_back(32'hA3);
        stall_mode = 1'b1; stall_now = cyc_n[0];
        run_block(4, 50, -1, 0);
        stall_mode = 1'b0; stall_now = 1'b0;
        check("stall_pops",       64'(n_pops),     64'd4);
        check("stall_rden_empty", 64'(n_rden_bad), 64'd0);
        check("stall_count",      64'(count),      64'd4);
        for (int k = 0; k < 4; k++) check("stall_word", 64'(word(k)), 64'(32'hA0 + k));
        check("stall_word4_cleared", 64'(word(4)), 64'd0);
        check("stall_read_cycles", 64'(n_read > 4), 64'd1);

        // Zero-length block
        q.push_back(32'h77);
        run_block(0, 10, -1, 0);
        check("len0_done_cyc", 64'(done_cyc), 64'(start_cyc + 1));
        check("len0_pops",     64'(n_pops),   64'd0);
        check("len0_word0",    64'(word(0)),  64'd0);
        check("len0_count",    64'(count),    64'd0);
        q.delete();

        // Oversized request clipped to the buffer size
        for (int i = 0; i < 40; i++) q.push_back(32'(100 + i));
        run_block(40, 100, -1, 0);
        check("len40_pops",   64'(n_pops),   64'd32);
        check("len40_count",  64'(count),    64'd32);
        check("len40_left",   64'(q.size()), 64'd8);
        check("len40_word0",  64'(word(0)),  64'd100);
        check("len40_word31", 64'(word(31)), 64'd131);
        q.delete();

        // Throttled 32-word block
        rate = 8'h1A;
        for (int i = 0; i < 32; i++) q.push_back(32'(200 + i));
        run_block(32, 5000, -1, 0);
        check("thr_pops", 64'(n_pops), 64'd32);
        check("thr_fewer_rden_than_read", 64'(n_pops < n_read), 64'd1);
        for (int k = 0; k < 32; k++) check("thr_word", 64'(word(k)), 64'(200 + k));
        rate = 8'hFF;
        q.delete();

        // Reset after 3 of 8 pops
        for (int i = 0; i < 8; i++) q.push_back(32'(300 + i));
        clear_stats();
        start = 1'b1; length = CW'(8);
        cyc();
        start = 1'b0;
        for (int g = 0; g < 20 && n_pops < 3; g++) cyc();
        check("mrst_pops_before", 64'(n_pops), 64'd3);
        rst = 1'b0;
        #1;
        check("mrst_busy",  64'(busy),     64'd0);
        check("mrst_done",  64'(done),     64'd0);
        check("mrst_rden",  64'(fif.rden), 64'd0);
        check("mrst_count", 64'(count),    64'd0);
        check("mrst_data",  64'(|data_o),  64'd0);
        repeat (2) cyc();
        rst = 1'b1;
        repeat (4) cyc();
        check("mrst_no_done",    64'(n_done), 64'd0);
        check("mrst_no_restart", 64'(n_pops), 64'd3);
        check("mrst_idle_busy",  64'(busy),   64'd0);
        q.delete();
        q.push_back(32'h55); q.push_back(32'h66);
        run_block(2, 20, -1, 0);
        check("mrst_after_pops",  64'(n_pops),  64'd2);
        check("mrst_after_count", 64'(count),   64'd2);
        check("mrst_after_w0",    64'(word(0)), 64'h55);
        check("mrst_after_w1",    64'(word(1)), 64'h66);

        // Second start during READ is ignored
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(32'(400 + i));
        run_block(4, 30, 2, 6);
        check("busy_start_pops",  64'(n_pops),   64'd4);
        check("busy_start_count", 64'(count),    64'd4);
        check("busy_start_left",  64'(q.size()), 64'd2);
        check("busy_start_done",  64'(done_cyc), 64'(start_cyc + 5));
        check("busy_start_w3",    64'(word(3)),  64'd403);
        check("busy_start_w4",    64'(word(4)),  64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
